// File: rtl/mmio_bus_fabric.sv
// MMIO bus fabric: decodes a CPU load/store onto one of NUM_SLAVES peripheral ports,
// waits for the slave's ready with a timeout, and keeps a sticky error with its address.
module mmio_bus_fabric #(
  parameter int          NUM_SLAVES = 4,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic [3:0]              byte_enable,
  input  logic                    mem_write,
  input  logic                    mem_read,
  output logic [31:0]             rdata,
  output logic                    busy,
  output logic [NUM_SLAVES-1:0]   s_sel,
  output logic [27:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_be,
  output logic                    s_we,
  output logic                    s_re,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  input  logic                    err_clear,
  output logic                    bus_error,
  output logic [31:0]             err_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [4:0]  NS        = 5'(NUM_SLAVES);

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [15:0]            wait_q, wait_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_SLAVES-1:0]  s_sel_q, s_sel_d;
  logic [27:0]            s_addr_q, s_addr_d;
  logic [31:0]            s_wdata_q, s_wdata_d;
  logic [3:0]             s_be_q, s_be_d;
  logic                   s_we_q, s_we_d;
  logic                   s_re_q, s_re_d;
  logic                   bus_error_q, bus_error_d;
  logic [31:0]            err_addr_q, err_addr_d;

  logic                   req;
  logic                   mapped;
  logic                   sel_ready;
  logic [31:0]            sel_rdata;
  logic [NUM_SLAVES-1:0]  dec_sel;
  logic                   err;
  logic [31:0]            err_addr_new;

  // Address decode and selected-slave return path; only the latched select is looked at,
  // so ready/data from other slaves can never complete the access.
  always_comb begin
    req       = mem_read | mem_write;
    mapped    = {1'b0, addr[31:28]} < NS;
    sel_ready = 1'b0;
    sel_rdata = '0;
    dec_sel   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_sel[i] = (addr[31:28] == 4'(i));
      if (s_sel_q[i]) begin
        sel_ready = sel_ready | s_ready[i];
        sel_rdata = sel_rdata | s_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    rdata_d      = rdata_q;
    s_sel_d      = s_sel_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_be_d       = s_be_q;
    s_we_d       = s_we_q;
    s_re_d       = s_re_q;
    bus_error_d  = bus_error_q;
    err_addr_d   = err_addr_q;
    err          = 1'b0;
    err_addr_new = {idx_q, s_addr_q};

    if (err_clear) bus_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d     = addr[31:28];
          s_addr_d  = addr[27:0];
          s_wdata_d = wdata;
          s_be_d    = byte_enable;
          wait_d    = '0;
          if (mapped) begin
            state_d = ACCESS;
            s_sel_d = dec_sel;
            s_we_d  = mem_write;
            s_re_d  = mem_read & ~mem_write;
          end else begin
            state_d      = DONE;
            rdata_d      = ERR_DATA;
            err          = 1'b1;
            err_addr_new = addr;
          end
        end
      end
      ACCESS: begin
        // Ready is tested before the timeout so a coinciding ready still completes cleanly.
        if (sel_ready || wait_q == WAIT_LAST) begin
          if (sel_ready) begin
            if (s_re_q) rdata_d = sel_rdata;
          end else begin
            rdata_d = ERR_DATA;
            err     = 1'b1;
          end
          state_d = DONE;
          s_sel_d = '0;
          s_we_d  = 1'b0;
          s_re_d  = 1'b0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new error beats a simultaneous clear; only the first error's address is kept.
    if (err) begin
      bus_error_d = 1'b1;
      if (!bus_error_q) err_addr_d = err_addr_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      s_sel_q     <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_be_q      <= '0;
      s_we_q      <= 1'b0;
      s_re_q      <= 1'b0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      s_sel_q     <= s_sel_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_be_q      <= s_be_d;
      s_we_q      <= s_we_d;
      s_re_q      <= s_re_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign busy      = (state_q == ACCESS) | ((state_q == IDLE) & req);
  assign rdata     = rdata_q;
  assign s_sel     = s_sel_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_be      = s_be_q;
  assign s_we      = s_we_q;
  assign s_re      = s_re_q;
  assign bus_error = bus_error_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: each transaction pushes its expected outcome to a
// scoreboard queue, which is popped and compared when the fabric drops busy.
module tb_mmio_bus_fabric;

  localparam int          NS  = 4;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic          clk, reset;
  logic [31:0]   addr, wdata, rdata, s_wdata, err_addr;
  logic [3:0]    byte_enable, s_be;
  logic          mem_write, mem_read, busy, s_we, s_re, err_clear, bus_error;
  logic [NS-1:0] s_sel, s_ready;
  logic [27:0]   s_addr;
  logic [32*NS-1:0] s_rdata;

  typedef struct {
    string       tag;
    int          busy_cyc;
    logic [3:0]  sel;
    logic        we, re;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_eaddr = '0;

  mmio_bus_fabric #(.NUM_SLAVES(NS), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byte_enable(byte_enable),
    .mem_write(mem_write), .mem_read(mem_read), .rdata(rdata), .busy(busy),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we),
    .s_re(s_re), .s_rdata(s_rdata), .s_ready(s_ready), .err_clear(err_clear),
    .bus_error(bus_error), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge with the fabric idle; delay < 0 means the slave never answers.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic w, input logic r, input int delay,
                         input logic [31:0] sdata, input logic clr_end);
    exp_t e, got;
    int idx, c;
    logic mapped, rdy_ok, fail_txn;
    logic [3:0] rmask, noise, acc_sel, acc_be;
    logic acc_we, acc_re;
    logic [27:0] acc_addr;
    logic [31:0] acc_wdata;
    idx    = int'(a[31:28]);
    mapped = (idx < NS);
    rdy_ok = mapped && delay >= 0 && delay <= TO - 1;
    rmask  = mapped ? 4'(1 << idx) : 4'b0;
    noise  = ~rmask;
    fail_txn = !rdy_ok;

    e.tag      = tag;
    e.busy_cyc = !mapped ? 1 : (rdy_ok ? 2 + delay : 1 + TO);
    e.sel      = rmask;
    e.we       = w;
    e.re       = r & ~w;
    if (fail_txn) begin
      m_rdata = ERR;
      if (!m_err) m_eaddr = a;
      m_err = 1'b1;
    end else if (r && !w) begin
      m_rdata = sdata;
    end
    e.rdata = m_rdata;
    e.err   = m_err;
    e.eaddr = m_eaddr;
    sbq.push_back(e);

    addr = a; wdata = wd; byte_enable = be; mem_write = w; mem_read = r;
    s_ready = noise;
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = (i == idx) ? sdata : ~sdata;

    c = 0;
    acc_sel = '0; acc_be = '0; acc_we = 1'b0; acc_re = 1'b0; acc_addr = '0; acc_wdata = '0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      c++;
      if (c == 2) begin
        acc_sel = s_sel; acc_be = s_be; acc_we = s_we; acc_re = s_re;
        acc_addr = s_addr; acc_wdata = s_wdata;
      end
      s_ready   = noise | ((c >= 2 && delay >= 0 && c - 2 >= delay) ? rmask : 4'b0);
      err_clear = clr_end && (c == e.busy_cyc);
      if (c > 40) break;
    end

    got = sbq.pop_front();
    chk({got.tag, " busy_cycles"}, 32'(c), 32'(got.busy_cyc));
    if (mapped) begin
      chk({got.tag, " s_sel"},   32'(acc_sel),   32'(got.sel));
      chk({got.tag, " s_we"},    32'(acc_we),    32'(got.we));
      chk({got.tag, " s_re"},    32'(acc_re),    32'(got.re));
      chk({got.tag, " s_addr"},  32'(acc_addr),  32'(a[27:0]));
      chk({got.tag, " s_be"},    32'(acc_be),    32'(be));
      chk({got.tag, " s_wdata"}, acc_wdata,      wd);
    end
    chk({got.tag, " done_strobes"}, 32'({s_sel, s_we, s_re}), 32'(0));
    chk({got.tag, " rdata"},     rdata,           got.rdata);
    chk({got.tag, " bus_error"}, 32'(bus_error),  32'(got.err));
    chk({got.tag, " err_addr"},  err_addr,        got.eaddr);

    mem_read = 1'b0; mem_write = 1'b0; s_ready = '0; err_clear = 1'b0;
    @(posedge clk); #1;
    chk({got.tag, " rdata_stable"}, rdata, got.rdata);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    m_err = 1'b0;
    chk("clear bus_error", 32'(bus_error), 32'(0));
    chk("clear err_addr_kept", err_addr, m_eaddr);
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; byte_enable = '0; mem_write = 1'b0; mem_read = 1'b1;
    s_rdata = '0; s_ready = '0; err_clear = 1'b0;
    #12;
    chk("rst busy_follows_req", 32'(busy), 32'(1));
    chk("rst rdata", rdata, 32'(0));
    chk("rst s_outputs", 32'({s_sel, s_we, s_re, s_be}), 32'(0));
    chk("rst s_addr", 32'(s_addr), 32'(0));
    chk("rst bus_error", 32'(bus_error), 32'(0));
    chk("rst err_addr", err_addr, 32'(0));
    mem_read = 1'b0; #1;
    chk("rst busy_idle", 32'(busy), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn("read_s1_w3",    32'h1000_0004, 32'h0,        4'hF,    1'b0, 1'b1,  3, 32'hCAFE0001, 1'b0);
    run_txn("write_s2_w0",   32'h2000_0010, 32'h55AA55AA, 4'b0011, 1'b1, 1'b0,  0, 32'h11111111, 1'b0);
    run_txn("read_unmapped", 32'h7000_0000, 32'h0,        4'hF,    1'b0, 1'b1,  0, 32'h22222222, 1'b0);
    clear_err();
    run_txn("timeout_rd",    32'h0000_0008, 32'h0,        4'hF,    1'b0, 1'b1, -1, 32'h33333333, 1'b0);
    run_txn("timeout_wr",    32'h0000_000C, 32'h01020304, 4'b1000, 1'b1, 1'b0, -1, 32'h44444444, 1'b0);
    run_txn("timeout_clr",   32'h0000_0020, 32'h0,        4'hF,    1'b0, 1'b1, -1, 32'h55555555, 1'b1);
    clear_err();
    run_txn("rd_wr_both",    32'h3000_0040, 32'h89ABCDEF, 4'b0101, 1'b1, 1'b1,  1, 32'h66666666, 1'b0);
    run_txn("read_s3_w2",    32'h3000_0100, 32'h0,        4'hF,    1'b0, 1'b1,  2, 32'h12345678, 1'b0);
    run_txn("read_s0_w0",    32'h0000_0000, 32'h0,        4'hF,    1'b0, 1'b1,  0, 32'hA5A5A5A5, 1'b0);
    run_txn("unmapped_err2", 32'hF000_0004, 32'h0,        4'hF,    1'b1, 1'b0,  0, 32'h77777777, 1'b0);

    // Reset in the middle of an access
    addr = 32'h2000_0000; mem_read = 1'b1; s_ready = '0;
    @(posedge clk); #1;
    chk("rstacc s_sel_before", 32'(s_sel), 32'(4'b0100));
    chk("rstacc busy_before", 32'(busy), 32'(1));
    #2 reset = 1'b1; #1;
    m_rdata = '0; m_err = 1'b0; m_eaddr = '0;
    chk("rstacc s_sel_async", 32'(s_sel), 32'(0));
    chk("rstacc bus_error", 32'(bus_error), 32'(0));
    chk("rstacc rdata", rdata, 32'(0));
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_txn("after_reset",   32'h2000_0008, 32'h0,        4'hF,    1'b0, 1'b1,  1, 32'h0BADF00D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bus_fabric.md
MMIO_BUS_FABRIC -- requirements
Module: mmio_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4: number of peripheral ports, range 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for s_ready, range 1..65535.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: read data returned on an error.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset input.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 addr  in  32  CPU byte address; addr[31:28] is the slave index.
REQ-008 wdata  in  32  CPU store data.
REQ-009 byte_enable  in  4  CPU byte lanes.
REQ-010 mem_write  in  1  store request, level, held while busy.
REQ-011 mem_read  in  1  load request, level, held while busy.
REQ-012 rdata  out  32  load result.
REQ-013 busy  out  1  CPU stall.
REQ-014 s_sel  out  NUM_SLAVES  one-hot slave select.
REQ-015 s_addr  out  28  latched addr[27:0].
REQ-016 s_wdata  out  32  latched store data.
REQ-017 s_be  out  4  latched byte_enable.
REQ-018 s_we  out  1  latched write strobe.
REQ-019 s_re  out  1  latched read strobe.
REQ-020 s_rdata  in  32*NUM_SLAVES  flattened slave read data; slave i occupies bits [32i+31:32i].
REQ-021 s_ready  in  NUM_SLAVES  per-slave completion.
REQ-022 err_clear  in  1  clears the sticky error.
REQ-023 bus_error  out  1  sticky error flag.
REQ-024 err_addr  out  32  address of the first error.

Function
REQ-025 SHALL implement an FSM with states IDLE, ACCESS, DONE.
REQ-026 In IDLE, busy SHALL be combinationally high whenever mem_read or mem_write is high.
REQ-027 On a request in IDLE, the block SHALL latch addr, wdata, byte_enable and the strobes at the clock edge.
REQ-028 When mem_write and mem_read are high together, the request SHALL be treated as a write and s_re SHALL be 0.
REQ-029 A request with index < NUM_SLAVES SHALL move IDLE->ACCESS; a request with index >= NUM_SLAVES SHALL move IDLE->DONE with an error and no s_sel.
REQ-030 In ACCESS, s_sel[index] SHALL be 1, busy SHALL be 1, and a wait counter SHALL start at 0 and increment by 1 each cycle.
REQ-031 In ACCESS, s_ready[index]=1 SHALL register rdata = s_rdata slice (reads) or hold the previous rdata (writes), and move to DONE.
REQ-032 In ACCESS, s_ready bits of non-selected slaves SHALL be ignored.
REQ-033 If the wait counter reaches TIMEOUT-1 without ready, the block SHALL register rdata = ERR_DATA, flag an error and move to DONE.
REQ-034 When ready and timeout coincide, ready SHALL win and no error is flagged.
REQ-035 In DONE, busy, s_sel, s_we and s_re SHALL be 0, rdata SHALL be stable, and the FSM SHALL return to IDLE after exactly 1 cycle.
REQ-036 The requester SHALL change or drop its request in DONE; a request still present in IDLE is a new transaction.
REQ-037 Latency SHALL be 2 + w cycles from request to busy low, where w is the number of cycles s_ready is low in ACCESS; an unmapped request takes 1 cycle.
REQ-038 On an error, bus_error SHALL set, and err_addr SHALL load only if bus_error was 0.
REQ-039 err_clear SHALL clear bus_error on the next edge; if an error occurs in the same cycle, the error SHALL win and err_addr SHALL keep its old value.

Reset
REQ-040 While reset is high, the outputs SHALL be: state IDLE, rdata 0, s_* outputs 0, bus_error 0, err_addr 0, wait counter 0; busy follows only the REQ-026 term.
REQ-041 Reset asserted during ACCESS SHALL abort the transaction immediately, with s_sel going to 0 asynchronously; no rdata or error update.

Verification
REQ-042 Read addr=32'h1000_0004, s_ready[1] high 3 cycles later, s_rdata slice1=32'hCAFE0001 -> s_sel=4'b0010, s_addr=28'h0000004, busy high 5 cycles, rdata=32'hCAFE0001, bus_error=0.
REQ-043 Write addr=32'h2000_0010, wdata=32'h55AA55AA, be=4'b0011, s_ready[2]=1 immediately -> s_we=1, s_be=4'b0011, busy high 2 cycles, rdata unchanged.
REQ-044 Read addr=32'h7000_0000 with NUM_SLAVES=4 -> no s_sel, busy high 1 cycle, rdata=32'hDEADBEEF, bus_error=1, err_addr=32'h7000_0000.
REQ-045 TIMEOUT=4, slave 0 never ready -> busy high 5 cycles, rdata=ERR_DATA, bus_error=1; a second timeout keeps the first err_addr; err_clear then gives bus_error=0.
REQ-046 mem_read and mem_write both high -> s_we=1, s_re=0; reset pulsed during ACCESS -> s_sel=0 at once, bus_error=0, next request completes normally.
